alu_exec_pipe: RTL

- Two-stage pipelined execution unit.
- Consumes the 3-bit ALU control code produced by the ALU decoder, together with two operands.
- Returns a registered result and status flags.
- Sits between decode/operand-fetch and writeback/branch-resolve.
- Uses valid/ready handshakes on both sides so cache-miss stalls downstream back-pressure cleanly.

---
 rtl/alu_exec_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_exec_pipe.sv
// ---------------------------------------------------------------------------
// alu_exec_pipe : two-stage valid/ready ALU execution pipe with status flags
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module alu_exec_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [2:0]       i_AluControl,
  input  logic [WIDTH-1:0] i_SrcA,
  input  logic [WIDTH-1:0] i_SrcB,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Result,
  output logic             o_Zero,
  output logic             o_Overflow,
  output logic             o_Illegal,
  output logic [CNT_W-1:0] o_IllegalCount
);

  localparam logic [2:0]       OP_ADD   = 3'b000;
  localparam logic [2:0]       OP_SUB   = 3'b001;
  localparam logic [2:0]       OP_AND   = 3'b010;
  localparam logic [2:0]       OP_OR    = 3'b011;
  localparam logic [2:0]       OP_SLT   = 3'b101;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               MSB      = WIDTH - 1;

  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_zero_q;
  logic             s2_ovf_q;
  logic             s2_ill_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             ovf_d;
  logic             ill_d;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  logic s2_adv_ok;
  logic in_xfer;
  logic out_xfer;
  logic s2_load;

  // Ready depends only on pipe state and i_Ready, never on i_Valid.
  assign s2_adv_ok = !s2_valid_q || i_Ready;
  assign o_Ready   = !s1_valid_q || s2_adv_ok;
  assign in_xfer   = i_Valid && o_Ready;
  assign out_xfer  = s2_valid_q && i_Ready;
  assign s2_load   = s1_valid_q && s2_adv_ok;

  assign sum  = s1_a_q + s1_b_q;
  assign diff = s1_a_q - s1_b_q;

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    ill_d    = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        result_d = sum;
        ovf_d    = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        result_d = diff;
        ovf_d    = (s1_a_q[MSB] != s1_b_q[MSB]) && (diff[MSB] != s1_a_q[MSB]);
      end
      OP_AND:  result_d = s1_a_q & s1_b_q;
      OP_OR:   result_d = s1_a_q | s1_b_q;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      default: ill_d = 1'b1;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (in_xfer) begin
      s1_valid_q <= 1'b1;
      s1_op_q    <= i_AluControl;
      s1_a_q     <= i_SrcA;
      s1_b_q     <= i_SrcB;
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_ill_q    <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q  <= 1'b1;
      s2_result_q <= result_d;
      s2_zero_q   <= zero_d;
      s2_ovf_q    <= ovf_d;
      s2_ill_q    <= ill_d;
    end else if (out_xfer) begin
      s2_valid_q  <= 1'b0;
    end
  end

  // Counts retired illegal ops, sticking at all-ones.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else if (out_xfer && s2_ill_q && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_Valid        = s2_valid_q;
  assign o_Result       = s2_result_q;
  assign o_Zero         = s2_zero_q;
  assign o_Overflow     = s2_ovf_q;
  assign o_Illegal      = s2_ill_q;
  assign o_IllegalCount = cnt_q;

endmodule

`default_nettype wire
